// File: rtl/apc_accum_ctrl.sv
// Stream accumulator controller around one 15-input parallel counter (APC_15).
// Optional build macro APC_ACC_BIPOLAR_EN selects the bipolar decode of out_count.

module apc_15 (
  input  logic [14:0] bits,
  output logic [3:0]  count
);
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 15; i++)
      count = count + {3'b000, bits[i]};
  end
endmodule

// state | meaning
// IDLE  | waiting for start; last result held on out_count
// RUN   | accepting beats until remain reaches its terminal count
// DONE  | result offered on out_valid until out_ready
module apc_accum_ctrl #(
  parameter int LEN_WIDTH = 16,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [14:0]          in_bits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH:0]   out_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] remain, len_q;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [3:0]           pop;
  logic [ACC_WIDTH:0]   res_run;
  logic                 beat, last_beat;

  apc_15 u_apc (
    .bits  (in_bits),
    .count (pop)
  );

  assign beat      = in_valid && (state == RUN);
  assign last_beat = beat && (remain == LEN_WIDTH'(1));
  assign acc_nxt   = acc + {{(ACC_WIDTH-4){1'b0}}, pop};

  // Result is formed from the post-beat sum so it is ready the cycle DONE is entered.
`ifdef APC_ACC_BIPOLAR_EN
  logic [ACC_WIDTH:0] len_x15;
  assign len_x15 = (ACC_WIDTH+1)'({len_q, 4'b0000}) - (ACC_WIDTH+1)'(len_q);
  assign res_run = {acc_nxt, 1'b0} - len_x15;
`else
  assign res_run = {1'b0, acc_nxt};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (cfg_len == '0) ? DONE : RUN;
      RUN:  if (last_beat) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN) || (state == DONE);
    in_ready  = (state == RUN);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      remain    <= '0;
      len_q     <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          len_q  <= cfg_len;
          remain <= cfg_len;
          // zero-length stream: both decodes of an empty sum are 0
          if (cfg_len == '0) out_count <= '0;
        end
        RUN: if (beat) begin
          acc    <= acc_nxt;
          remain <= remain - LEN_WIDTH'(1);
          if (last_beat) out_count <= res_run;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apc_accum_ctrl.sv
// Randomised + directed bench for apc_accum_ctrl against a transaction-level model.
module tb_apc_accum_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        busy, in_ready, out_valid;
  logic        in_valid = 1'b0;
  logic [14:0] in_bits = '0;
  logic        out_ready = 1'b0;
  logic [20:0] out_count;

  int tests = 0;
  int fails = 0;

  apc_accum_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

`ifdef APC_ACC_BIPOLAR_EN
  localparam logic [20:0] E1 = 21'd60, E2 = 21'd3, E3 = 21'd0, E4 = -21'sd30, E5 = -21'sd11;
`else
  localparam logic [20:0] E1 = 21'd60, E2 = 21'd24, E3 = 21'd0, E4 = 21'd0, E5 = 21'd2;
`endif
  localparam logic [20:0] E6 = 21'd983025;

  function automatic logic [20:0] decode(int sum, int len);
`ifdef APC_ACC_BIPOLAR_EN
    return 21'(2 * sum - 15 * len);
`else
    return 21'(sum);
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 waiting, 1 collecting beats, 2 offering result.
  int          m_phase = 0;
  int          m_left = 0, m_sum = 0, m_len = 0;
  logic [20:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_left <= 0; m_sum <= 0; m_len <= 0; m_res <= '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_len <= int'(cfg_len);
        m_sum <= 0;
        m_left <= int'(cfg_len);
        if (cfg_len == 0) begin m_phase <= 2; m_res <= decode(0, 0); end
        else m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_sum  <= m_sum + $countones(in_bits);
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_phase <= 2;
          m_res   <= decode(m_sum + $countones(in_bits), m_len);
        end
      end
    end else if (out_ready) begin
      m_phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("in_ready", 32'(in_ready), 32'(m_phase == 1));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase != 1) check("out_count", 32'(out_count), 32'(m_res));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_start(int len);
    start = 1'b1; cfg_len = 16'(len);
    tick();
    start = 1'b0; cfg_len = 16'($urandom);
  endtask

  task automatic send_beat(logic [14:0] b, bit rnd_start);
    int n = 0;
    in_valid = 1'b1; in_bits = b;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("timeout_in_ready", 32'(in_ready), 32'd1);
    if (rnd_start) begin start = ($urandom_range(0, 3) == 0); cfg_len = 16'($urandom); end
    tick();
    start = 1'b0; in_valid = 1'b0; in_bits = 15'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) check("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake(int hold);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #13;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    tick();

    // 4 full beats back-to-back; result visible the cycle after the 4th beat
    do_start(4);
    repeat (4) send_beat(15'h7FFF, 1'b0);
    check("t1_valid_next", 32'(out_valid), 32'd1);
    check("t1_count", 32'(out_count), 32'(E1));
    handshake(0);

    // stalls between beats hold state
    do_start(3);
    send_beat(15'h0001, 1'b0); repeat (2) tick();
    send_beat(15'h7FFF, 1'b0); repeat (2) tick();
    send_beat(15'h0F0F, 1'b0);
    check("t2_count", 32'(out_count), 32'(E2));
    handshake(1);

    // zero-length stream goes straight to DONE
    do_start(0);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_count", 32'(out_count), 32'(E3));
    handshake(0);

    // result held while consumer stalls; start pulses in DONE ignored
    do_start(2);
    send_beat(15'h0000, 1'b0);
    send_beat(15'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; cfg_len = 16'd7;
      tick();
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_count", 32'(out_count), 32'(E4));
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("t4_idle_after", 32'(busy), 32'd0);
    tick();
    check("t4_still_idle", 32'(busy), 32'd0);

    // async reset mid-stream
    do_start(8);
    repeat (3) send_beat(15'h7FFF, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd0);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_out_count", 32'(out_count), 32'd0);
    #5 rst = 1'b0;
    tick();
    do_start(1);
    send_beat(15'h0003, 1'b0);
    check("t5_count", 32'(out_count), 32'(E5));
    handshake(0);

    // randomised streams with stalls, consumer delays and stray starts
    for (int s = 0; s < 30; s++) begin
      int len;
      len = $urandom_range(0, 12);
      do_start(len);
      for (int b = 0; b < len; b++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          start = ($urandom_range(0, 3) == 0); cfg_len = 16'($urandom);
          tick();
        end
        start = 1'b0;
        send_beat(15'($urandom), 1'b1);
      end
      wait_valid();
      handshake($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    // maximum stream length
    do_start(65535);
    for (int b = 0; b < 65535; b++) send_beat(15'h7FFF, 1'b0);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_count", 32'(out_count), 32'(E6));
    handshake(0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
